// File: rtl/q_pkt_source_if.sv
// Handshake bundle between the packet-length source and the queue server.
// The master modport is the source side; slave is the server/upstream side.
interface q_pkt_source_if #(
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  len_in;
    logic          len_we;
    logic          full;
    logic [CW-1:0] count;
    logic          drop_err;
    logic          bool_ready;
    logic          bool_go;
    logic          ena_n;
    logic [W-1:0]  pkt_len;
    logic          pkt_done;

    modport master (
        input  len_in, len_we, bool_ready, bool_go,
        output full, count, drop_err, ena_n, pkt_len, pkt_done
    );

    modport slave (
        output len_in, len_we, bool_ready, bool_go,
        input  full, count, drop_err, ena_n, pkt_len, pkt_done
    );
endinterface

// File: rtl/q_pkt_source.sv
// Packet-length source: queues lengths, grants the server after a delay,
// and counts the active packet down while the server drains it.
module q_pkt_source #(
    parameter int W       = 8,
    parameter int DEPTH   = 4,
    parameter int ACK_DLY = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    q_pkt_source_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE, WAIT_ACK, GRANT, SEND, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0]    dly_q, dly_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          drop_q, drop_d;
    logic          done_q, done_d;
    logic          ena_n_q, ena_n_d;
    logic [W-1:0]  pkt_len_q, pkt_len_d;
    logic          push, pop;
    logic [W-1:0]  head;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        dly_d    = dly_q;
        mem_d    = mem_q;
        pop      = 1'b0;
        done_d   = 1'b0;
        push     = bus.len_we && !full_q && (bus.len_in != '0);
        drop_d   = bus.len_we && !push;

        unique case (state_q)
            IDLE: begin
                if (bus.bool_ready && count_q != '0) begin
                    state_d = WAIT_ACK;
                    dly_d   = 4'(ACK_DLY - 1);
                end
            end
            WAIT_ACK: begin
                if (!bus.bool_ready) begin
                    state_d = IDLE;
                end else if (dly_q == '0) begin
                    state_d = GRANT;
                end else begin
                    dly_d = dly_q - 4'd1;
                end
            end
            GRANT: begin
                if (bus.bool_go) state_d = SEND;
            end
            SEND: begin
                if (pkt_len_q == '0) begin
                    state_d = DONE;
                end else if (bus.bool_go && pkt_len_q == W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.bool_go) begin
                    pop     = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = bus.len_in;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
        full_d  = (count_d == CW'(DEPTH));

        // an entry written this edge may become the head immediately
        head = (push && rd_ptr_d == wr_ptr_q) ? bus.len_in
                                              : mem_q[rd_ptr_d];

        unique case (state_d)
            SEND: begin
                pkt_len_d = pkt_len_q;
                if (state_q == SEND && bus.bool_go && pkt_len_q != '0)
                    pkt_len_d = pkt_len_q - W'(1);
            end
            DONE:    pkt_len_d = '0;
            default: pkt_len_d = (count_d != '0) ? head : '0;
        endcase

        ena_n_d = !(state_d == GRANT || state_d == SEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            dly_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            drop_q    <= 1'b0;
            done_q    <= 1'b0;
            ena_n_q   <= 1'b1;
            pkt_len_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            dly_q     <= dly_d;
            mem_q     <= mem_d;
            count_q   <= count_d;
            full_q    <= full_d;
            drop_q    <= drop_d;
            done_q    <= done_d;
            ena_n_q   <= ena_n_d;
            pkt_len_q <= pkt_len_d;
        end
    end

    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.drop_err = drop_q;
    assign bus.pkt_done = done_q;
    assign bus.ena_n    = ena_n_q;
    assign bus.pkt_len  = pkt_len_q;
endmodule
